// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: shared types and constants for the next-PC sequencer.
//   PC_W                 - program counter width (fixed at 16 in this core)
//   pc_t                 - program counter / address type
//   seq_state_e          - sequencer FSM state (RUN, HALT)
//   RESET_PC_DEFAULT     - default reset PC
//   IRQ_VECTOR_DEFAULT   - default interrupt entry address
//   pc_inc()             - modulo-2^16 PC increment
package pc_seq_pkg;

  localparam int PC_W = 16;

  typedef logic [PC_W-1:0] pc_t;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } seq_state_e;

  localparam pc_t RESET_PC_DEFAULT   = 16'h0000;
  localparam pc_t IRQ_VECTOR_DEFAULT = 16'h0100;

  // Wrap-around past 0xFFFF is silent by design.
  function automatic pc_t pc_inc(input pc_t pc);
    return pc + pc_t'(1);
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: control and status bundle between the core datapath and
// the next-PC sequencer.
//   Control (core -> sequencer): stall, branch_taken, branch_offset, jump,
//     jump_target, halt_req, reti, irq
//   Status (sequencer -> core): pc, epc, irq_ack, ie, halted
//   modport master - core / decode side, drives control
//   modport slave  - the sequencer
interface pc_sequencer_if;
  import pc_seq_pkg::*;

  logic stall;
  logic branch_taken;
  pc_t  branch_offset;
  logic jump;
  pc_t  jump_target;
  logic halt_req;
  logic reti;
  logic irq;

  pc_t  pc;
  pc_t  epc;
  logic irq_ack;
  logic ie;
  logic halted;

  modport master (
    output stall, branch_taken, branch_offset, jump, jump_target,
           halt_req, reti, irq,
    input  pc, epc, irq_ack, ie, halted
  );

  modport slave (
    input  stall, branch_taken, branch_offset, jump, jump_target,
           halt_req, reti, irq,
    output pc, epc, irq_ack, ie, halted
  );

endinterface

// File: rtl/next_pc_mux.sv
// next_pc_mux: combinational priority select of the PC the current
// instruction produces when it retires normally.
//   Priority: reti > halt_req > jump > branch_taken > sequential.
//   pc, epc          - current PC and saved return PC
//   reti, halt_req   - return-from-interrupt / HALT instruction
//   hold_on_halt     - 1: HALT holds pc; 0: HALT behaves as sequential
//                      (used when computing the interrupt return address)
//   jump, jump_target             - absolute jump
//   branch_taken, branch_offset   - relative branch from pc+1
//   next_pc          - selected address
module next_pc_mux
  import pc_seq_pkg::*;
(
  input  pc_t  pc,
  input  pc_t  epc,
  input  logic reti,
  input  logic halt_req,
  input  logic hold_on_halt,
  input  logic jump,
  input  pc_t  jump_target,
  input  logic branch_taken,
  input  pc_t  branch_offset,
  output pc_t  next_pc
);

  pc_t seq_pc;

  // NOTE: every output of a combinational block gets a default first so
  // no path leaves it unassigned and a latch is never inferred.
  always_comb begin
    seq_pc  = pc_inc(pc);
    next_pc = seq_pc;
    if (reti) begin
      next_pc = epc;
    end else if (halt_req && hold_on_halt) begin
      next_pc = pc;
    end else if (jump) begin
      next_pc = jump_target;
    end else if (branch_taken) begin
      // Two's-complement offset added modulo 2^16.
      next_pc = seq_pc + branch_offset;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: owns the program counter, the RUN/HALT FSM and single-level
// interrupt state (epc, ie, irq_ack) of the single-cycle core.
//   clk    - core clock, rising edge
//   reset  - asynchronous active-low reset
//   bus    - pc_sequencer_if.slave (control in, pc/epc/irq_ack/ie/halted out)
// All outputs come straight from flops; no input reaches an output
// combinationally.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter pc_t RESET_PC   = RESET_PC_DEFAULT,
  parameter pc_t IRQ_VECTOR = IRQ_VECTOR_DEFAULT
) (
  input  logic           clk,
  input  logic           reset,
  pc_sequencer_if.slave  bus
);

  seq_state_e state_q, state_d;
  pc_t        pc_q, pc_d;
  pc_t        epc_q, epc_d;
  logic       ie_q, ie_d;
  logic       irq_ack_q, irq_ack_d;

  pc_t        run_next_pc;
  pc_t        irq_ret_pc;

  // Normal retirement target: HALT holds the PC.
  next_pc_mux u_run_mux (
    .pc            (pc_q),
    .epc           (epc_q),
    .reti          (bus.reti),
    .halt_req      (bus.halt_req),
    .hold_on_halt  (1'b1),
    .jump          (bus.jump),
    .jump_target   (bus.jump_target),
    .branch_taken  (bus.branch_taken),
    .branch_offset (bus.branch_offset),
    .next_pc       (run_next_pc)
  );

  // Return address saved on interrupt entry: the interrupted instruction
  // retires, and a HALT it carries is dropped (treated as sequential).
  next_pc_mux u_ret_mux (
    .pc            (pc_q),
    .epc           (epc_q),
    .reti          (bus.reti),
    .halt_req      (bus.halt_req),
    .hold_on_halt  (1'b0),
    .jump          (bus.jump),
    .jump_target   (bus.jump_target),
    .branch_taken  (bus.branch_taken),
    .branch_offset (bus.branch_offset),
    .next_pc       (irq_ret_pc)
  );

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    epc_d     = epc_q;
    ie_d      = ie_q;
    irq_ack_d = 1'b0;

    unique case (state_q)
      ST_RUN: begin
        if (bus.irq && ie_q && !bus.stall) begin
          epc_d     = irq_ret_pc;
          pc_d      = IRQ_VECTOR;
          ie_d      = 1'b0;
          irq_ack_d = 1'b1;
        end else if (bus.stall) begin
          // Everything holds; other control inputs are ignored.
        end else begin
          pc_d = run_next_pc;
          if (bus.reti) begin
            ie_d = 1'b1;
          end else if (bus.halt_req) begin
            state_d = ST_HALT;
          end
        end
      end

      ST_HALT: begin
        // Only an enabled interrupt (or reset) leaves HALT.
        if (bus.irq && ie_q) begin
          epc_d     = pc_inc(pc_q);
          pc_d      = IRQ_VECTOR;
          ie_d      = 1'b0;
          irq_ack_d = 1'b1;
          state_d   = ST_RUN;
        end
      end

      default: state_d = ST_RUN;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others, regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_RUN;
      pc_q      <= RESET_PC;
      epc_q     <= '0;
      ie_q      <= 1'b1;
      irq_ack_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      epc_q     <= epc_d;
      ie_q      <= ie_d;
      irq_ack_q <= irq_ack_d;
    end
  end

  assign bus.pc      = pc_q;
  assign bus.epc     = epc_q;
  assign bus.ie      = ie_q;
  assign bus.irq_ack = irq_ack_q;
  assign bus.halted  = (state_q == ST_HALT);

endmodule
